// File: rtl/elevador_pkg.sv
// Shared types, floor constants and small floor-mask helpers for the elevator controller.
package elevador_pkg;
  typedef enum logic [2:0] {PARADO, SUBINDO, DESCENDO, PORTA_ABERTA, FALHA} estado_t;
  typedef enum logic {UP, DOWN} dir_t;
  typedef logic [1:0] andar_t;

  localparam int     N_ANDARES = 3;
  localparam andar_t ANDAR_MIN = 2'd1;
  localparam andar_t ANDAR_MAX = 2'd3;

  function automatic logic [N_ANDARES-1:0] um_quente(input andar_t a);
    case (a)
      2'd1:    um_quente = 3'b001;
      2'd2:    um_quente = 3'b010;
      2'd3:    um_quente = 3'b100;
      default: um_quente = 3'b000;
    endcase
  endfunction

  // Floor of a one-hot sensor word; 0 when not exactly one bit is set.
  function automatic andar_t decodifica(input logic [N_ANDARES-1:0] s);
    case (s)
      3'b001:  decodifica = 2'd1;
      3'b010:  decodifica = 2'd2;
      3'b100:  decodifica = 2'd3;
      default: decodifica = 2'd0;
    endcase
  endfunction

  function automatic logic [N_ANDARES-1:0] acima(input andar_t a);
    case (a)
      2'd1:    acima = 3'b110;
      2'd2:    acima = 3'b100;
      default: acima = 3'b000;
    endcase
  endfunction

  function automatic logic [N_ANDARES-1:0] abaixo(input andar_t a);
    case (a)
      2'd2:    abaixo = 3'b001;
      2'd3:    abaixo = 3'b011;
      default: abaixo = 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/elevador_porta_segura.sv
// Door interlock: opening allowed only with the motor off and the car aligned at one floor.
module porta_segura
  import elevador_pkg::*;
(
  input  logic                 subir,
  input  logic                 descer,
  input  logic [N_ANDARES-1:0] sensor,
  output logic                 permitido
);
  assign permitido = !subir && !descer && (decodifica(sensor) != 2'd0);
endmodule

// File: rtl/elevador_controlador.sv
// 3-floor elevator controller: call latching, SCAN scheduling, door timer, travel timeout, fault latch.
module elevador_controlador
  import elevador_pkg::*;
#(
  parameter int TEMPO_PORTA   = 4,
  parameter int TEMPO_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] chamada,
  input  logic [N_ANDARES-1:0] sensor,
  input  logic                 obstaculo,
  output logic                 subir,
  output logic                 descer,
  output logic                 porta,
  output logic [N_ANDARES-1:0] pendente,
  output andar_t               andar_atual,
  output logic                 falha
);
  localparam int TMAX = (TEMPO_PORTA > TEMPO_TIMEOUT) ? TEMPO_PORTA : TEMPO_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] T_PORTA   = CW'(TEMPO_PORTA);
  localparam logic [CW-1:0] T_TIMEOUT = CW'(TEMPO_TIMEOUT);
  localparam logic [CW-1:0] T_UM      = CW'(1);

  estado_t               estado, estado_n;
  dir_t                  dir, dir_n;
  andar_t                andar_n, andar_sensor;
  logic [N_ANDARES-1:0]  pend_n, limpa, absorve, aqui;
  logic [CW-1:0]         timer, timer_n;
  logic                  multi, novo_andar, permitido;

  assign aqui         = um_quente(andar_atual);
  assign andar_sensor = decodifica(sensor);
  assign novo_andar   = (andar_sensor != 2'd0) && (andar_sensor != andar_atual);
  assign multi        = (sensor[0] & sensor[1]) | (sensor[0] & sensor[2]) | (sensor[1] & sensor[2]);

  always_comb begin
    estado_n = estado;
    dir_n    = dir;
    andar_n  = andar_atual;
    timer_n  = timer;
    limpa    = '0;
    absorve  = '0;
    if (multi) begin
      estado_n = FALHA;
    end else begin
      case (estado)
        PARADO: begin
          if (|(pendente & aqui) && sensor == aqui) begin
            estado_n = PORTA_ABERTA;
            timer_n  = T_PORTA;
            limpa    = aqui;
          end else if (|(pendente & ((dir == UP) ? acima(andar_atual) : abaixo(andar_atual)))) begin
            estado_n = (dir == UP) ? SUBINDO : DESCENDO;
            timer_n  = T_TIMEOUT;
          end else if (|(pendente & ((dir == UP) ? abaixo(andar_atual) : acima(andar_atual)))) begin
            dir_n    = (dir == UP) ? DOWN : UP;
            estado_n = (dir == UP) ? DESCENDO : SUBINDO;
            timer_n  = T_TIMEOUT;
          end
        end
        SUBINDO, DESCENDO: begin
          if (novo_andar) begin
            andar_n = andar_sensor;
            timer_n = T_TIMEOUT;
            // End floors always stop the car, pending or not.
            if (|(pendente & sensor) ||
                (estado == SUBINDO  && andar_sensor == ANDAR_MAX) ||
                (estado == DESCENDO && andar_sensor == ANDAR_MIN)) begin
              estado_n = PORTA_ABERTA;
              timer_n  = T_PORTA;
              limpa    = sensor;
            end
          end else if (timer <= T_UM) begin
            estado_n = FALHA;
          end else begin
            timer_n = timer - T_UM;
          end
        end
        PORTA_ABERTA: begin
          absorve = chamada & aqui;
          if (sensor == '0) begin
            estado_n = FALHA;
          end else if (obstaculo || |absorve) begin
            timer_n = T_PORTA;
          end else if (timer <= T_UM) begin
            estado_n = PARADO;
            timer_n  = '0;
          end else begin
            timer_n = timer - T_UM;
          end
        end
        default: ;
      endcase
    end
    // A new call beats a same-edge clear; only the open-door floor swallows calls.
    pend_n = (pendente & ~limpa) | (chamada & ~absorve);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= PARADO;
      dir         <= UP;
      andar_atual <= ANDAR_MIN;
      pendente    <= '0;
      timer       <= '0;
      subir       <= 1'b0;
      descer      <= 1'b0;
      falha       <= 1'b0;
    end else begin
      estado      <= estado_n;
      dir         <= dir_n;
      andar_atual <= andar_n;
      pendente    <= pend_n;
      timer       <= timer_n;
      subir       <= (estado_n == SUBINDO);
      descer      <= (estado_n == DESCENDO);
      falha       <= (estado_n == FALHA);
    end
  end

  porta_segura u_porta (
    .subir     (subir),
    .descer    (descer),
    .sensor    (sensor),
    .permitido (permitido)
  );

  assign porta = (estado == PORTA_ABERTA) && permitido;
endmodule
